// File: rtl/alu_acc_sequencer.sv
// alu_acc_sequencer
//   Command-driven accumulator/sequencer placed directly upstream of the 4-bit
//   team ALU. Commands are buffered in a small FIFO. The ALU operands and op
//   code are driven from registers, with inA always being the accumulator. The
//   ALU's combinational answer is captured back into the accumulator, and each
//   result is returned over a valid/ready handshake.
//
//   Optional feature macro: ALU_ACC_CNT_EN
//     When defined, adds the op_count output, a count of completed commands
//     that wraps from 255 to 0.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  FIFO can accept a command (not full)
//   cmd_load   in   1 = load cmd_data into the accumulator, ALU answer ignored
//   cmd_op     in   ALU op code, forwarded unchanged
//   cmd_data   in   operand B, or the value to load
//   alu_inA    out  ALU inA (the accumulator)
//   alu_inB    out  ALU inB
//   alu_op     out  ALU op
//   alu_ans    in   ALU answer, combinational from inA/inB/op
//   res_valid  out  result present
//   res_ready  in   consumer accepts the result
//   res_data   out  result (the new accumulator value)
//   op_count   out  completed commands (only with ALU_ACC_CNT_EN)
//
// FSM states
//   state  | meaning
//   IDLE   | nothing in flight; pop as soon as the FIFO holds a command
//   EXEC   | ALU sees {acc, B, op} for one full cycle; capture at the closing edge
//   RESP   | result held on res_data until res_ready; may pop the next command directly

module alu_acc_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] alu_inA,
  output logic [WIDTH-1:0] alu_inB,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_ans,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data
`ifdef ALU_ACC_CNT_EN
  ,
  output logic [7:0]       op_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;

  logic [WIDTH-1:0] r_fifo_data [DEPTH];
  logic [1:0]       r_fifo_op   [DEPTH];
  logic [DEPTH-1:0] r_fifo_load;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_inb;
  logic [1:0]       r_op;
  logic             r_load;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_valid;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_res_hs;
  logic [WIDTH-1:0] w_next_acc;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_push   = cmd_valid & ~w_full;
  assign w_res_hs = r_res_valid & res_ready;

  // A pop happens from IDLE, or straight out of RESP on the result handshake
  // so back-to-back commands keep a 2-cycle cadence.
  assign w_pop = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_RESP) & w_res_hs));

  // Loads bypass the ALU; otherwise the ALU answer is taken unmodified.
  assign w_next_acc = r_load ? r_inb : alu_ans;

  // cmd_ready looks only at full, so a simultaneous pop never frees a slot early.
  assign cmd_ready = ~w_full;
  assign alu_inA   = r_acc;
  assign alu_inB   = r_inb;
  assign alu_op    = r_op;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;

  // FIFO storage. It is not reset, because the entries are only read while count > 0.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= cmd_data;
      r_fifo_op[r_wr_ptr]   <= cmd_op;
      r_fifo_load[r_wr_ptr] <= cmd_load;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_inb       <= '0;
      r_op        <= '0;
      r_load      <= 1'b0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_inb   <= r_fifo_data[r_rd_ptr];
            r_op    <= r_fifo_op[r_rd_ptr];
            r_load  <= r_fifo_load[r_rd_ptr];
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_acc       <= w_next_acc;
          r_res_data  <= w_next_acc;
          r_res_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (w_res_hs) begin
            r_res_valid <= 1'b0;
            if (w_pop) begin
              r_inb   <= r_fifo_data[r_rd_ptr];
              r_op    <= r_fifo_op[r_rd_ptr];
              r_load  <= r_fifo_load[r_rd_ptr];
              r_state <= S_EXEC;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_ACC_CNT_EN
  logic [7:0] r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_op_count <= '0;
    else if (w_res_hs) r_op_count <= r_op_count + 8'd1;
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: doc/alu_acc_sequencer.md
# alu_acc_sequencer

Command-driven accumulator and sequencer for the team's 4-bit ALU. It buffers incoming commands in a small FIFO and drives the ALU's `inA`/`inB`/`op` from registers, with `inA` always the accumulator. It captures the ALU's combinational `ans` back into the accumulator and returns each result over a valid/ready handshake. It sits directly upstream of the ALU, replacing free-running operand stimulus with a clocked, back-pressured command stream.

## Interface
- `WIDTH`, 4, datapath width (matches ALU `inA`/`inB`/`ans`)
- `DEPTH`, 4, command FIFO entries (power of two, ≥2)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: FIFO can accept (= !full)
- `cmd_load` in 1: 1 = load `cmd_data` into accumulator, ALU result ignored
- `cmd_op` in 2: ALU op code, forwarded unchanged
- `cmd_data` in WIDTH: operand B (or load value)
- `alu_inA` out WIDTH: to ALU `inA` (= accumulator)
- `alu_inB` out WIDTH: to ALU `inB`
- `alu_op` out 2: to ALU `op`
- `alu_ans` in WIDTH: from ALU `ans`, combinational
- `res_valid` out 1: result present
- `res_ready` in 1: consumer accepts
- `res_data` out WIDTH: result (= new accumulator value)
- `op_count` out 8: completed commands (only with `ALU_ACC_CNT_EN`)

## Operation
- FIFO push on `cmd_valid & cmd_ready`; stores {load, op, data}; pointers wrap modulo DEPTH; count tracks full/empty.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if FIFO not empty, pop and latch op/data into `alu_op`/`alu_inB`, load flag internally; go to EXEC.
  - EXEC: ALU sees {acc, B, op} for one full cycle. At the closing edge, acc <= load ? latched data : `alu_ans`, res_data <= same value, res_valid <= 1. Go to RESP.
  - RESP: hold res_valid/res_data stable until `res_ready`. On `res_valid & res_ready`: if FIFO not empty, pop directly and go to EXEC (res_valid <= 0); else go to IDLE (res_valid <= 0).
- Push and pop in the same cycle are both honoured; count unchanged. `cmd_ready` depends only on full (no pass-through on pop).
- Arithmetic is done by the ALU only; this block never modifies `alu_ans` and never uses carry. WIDTH-bit results wrap naturally.
- Commands complete strictly in acceptance order.

## Timing
- Reset (async, immediate): acc, `alu_inA`/`alu_inB`/`alu_op`, `res_data` = 0; `res_valid` = 0; FIFO empty so `cmd_ready` = 1; FSM = IDLE; `op_count` = 0.
- Reset mid-operation: the in-flight command, all queued commands and any pending result are discarded. No result is presented after release.
- Latency, empty FIFO, FSM idle: accept at edge E0, pop at E1, result with res_valid = 1 after E2.
- Throughput with `res_ready` held high: one result every 2 cycles.
- Capacity: DEPTH queued plus 1 in flight. With `res_ready` = 0, the (DEPTH+1)th accepted command makes `cmd_ready` fall.
- `alu_inA` changes only at the EXEC closing edge. `alu_inB`/`alu_op` change only at pop.

## Configuration
- `ALU_ACC_CNT_EN` defined:
  - `op_count` port exists.
  - It increments on every `res_valid & res_ready`, wrapping 255 -> 0.
  - It resets to 0.
- `ALU_ACC_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
Bench uses WIDTH=4, DEPTH=4, the team ALU (op 00 add, 01 sub).
- Reset check: hold `rst_n`=0 -> all outputs 0, `cmd_ready`=1. Release with no commands -> outputs stay 0.
- Load then add: load 0110, then op 00 data 0101, `res_ready`=1 -> `res_data` 0110 then 1011, `alu_inA`=1011 afterwards. The second result appears 2 cycles after the first.
- Sub wrap: load 0011, then op 01 data 0101 -> `res_data` 1110.
- Back-pressure: `res_ready`=0, push 6 loads 0001..0110 back-to-back -> 5 accepted, `cmd_ready`=0 on the 6th. Raise `res_ready` -> results 0001..0101 in order, with `res_data` stable while stalled.
- Async reset in RESP: assert `rst_n`=0 mid-cycle with `res_valid`=1 and 2 queued -> `res_valid`, acc, `alu_inA` = 0 before the next edge. After release no stale result appears.
- With `ALU_ACC_CNT_EN`: complete 257 commands -> `op_count` = 1, passing through 0 after the 256th handshake.
